// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage control, memory and IF/ID output bundle
interface fetch_stage_if;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        MisalignF;

    // Fetch stage side: consumes hazard/redirect controls and memory data.
    modport slave (
        input  StallF, StallD, FlushD, PCSrcE, PCTargetE, InstrF,
        output PCF, InstrD, PCD, PCPlus4D, ValidD, MisalignF
    );

    // Pipeline/memory side: drives controls, observes fetch results.
    modport master (
        output StallF, StallD, FlushD, PCSrcE, PCTargetE, InstrF,
        input  PCF, InstrD, PCD, PCPlus4D, ValidD, MisalignF
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction fetch stage with IF/ID pipeline register
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.slave  bus
);
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        misalign;

    // Sequential PC wraps naturally at 2^32; redirect targets drop their low bits.
    assign pc_plus4 = pc + 32'd4;
    assign pc_next  = bus.PCSrcE ? {bus.PCTargetE[31:2], 2'b00} : pc_plus4;

    // PC register: a redirect must win over a fetch stall or the branch is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (bus.PCSrcE || !bus.StallF) begin
            pc <= pc_next;
        end
    end

    // IF/ID register: flush inserts a bubble even when decode is stalled.
    always_ff @(posedge clk) begin
        if (reset || bus.FlushD) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= 32'h0;
            pc_plus4_d <= 32'h0;
            valid_d    <= 1'b0;
        end else if (!bus.StallD) begin
            instr_d    <= bus.InstrF;
            pc_d       <= pc;
            pc_plus4_d <= pc_plus4;
            valid_d    <= 1'b1;
        end
    end

    // Sticky flag recording any redirect to a non-word-aligned target.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign <= 1'b0;
        end else if (bus.PCSrcE && (bus.PCTargetE[1:0] != 2'b00)) begin
            misalign <= 1'b1;
        end
    end

    assign bus.PCF       = pc;
    assign bus.InstrD    = instr_d;
    assign bus.PCD       = pc_d;
    assign bus.PCPlus4D  = pc_plus4_d;
    assign bus.ValidD    = valid_d;
    assign bus.MisalignF = misalign;
endmodule
